tally_arbiter: RTL and testbench

Round-robin controller that shares one bounded increment datapath (tally `sn`, index `i`) among NREQ requesters. Each granted cycle advances the shared pair by one and credits the winning requester, until the index passes LIMIT. The block sits in front of the arithmetic core as its sole sequencer. It owns the start/run/done lifecycle, grant fairness and per-requester accounting.

---
 rtl/tally_pkg.sv | 15 +
 rtl/tally_arbiter_rr_pick.sv | 32 +++
 rtl/tally_arbiter.sv | 122 ++++++++++++
 tb/tb_tally_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tally_pkg.sv
// Shared types and default sizing for the tally arbiter slice.
// The arbiter FSM walks IDLE -> RUN -> DONE, and a start pulse re-arms it from DONE.
package tally_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int LIMIT_DEF = 70;

endpackage

// File: rtl/tally_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the first set req bit at or above ptr wins,
// and the search wraps around to bit 0 when it runs off the top.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  int k;

  // NOTE: every output gets a default before the scan; without defaults this block would infer latches.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(ptr) + off) % NREQ;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        idx       = PW'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tally_arbiter.sv
// Round-robin sequencer for the shared sn/i increment datapath.
// Each granted cycle adds one to the shared pair and one to the winner's credit counter.
module tally_arbiter
  import tally_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int LIMIT = LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      sn,
  output logic [WIDTH-1:0]      i,
  output logic [NREQ*WIDTH-1:0] credit,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  if (NREQ < 2 || NREQ > 8 || (LIMIT + 1) >= (1 << WIDTH)) begin : g_bad_param
    $error("tally_arbiter: NREQ must be 2..8 and LIMIT+1 must be below 2**WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sn_q, sn_d, i_q, i_d;
  logic [WIDTH-1:0] credit_q [NREQ];
  logic [WIDTH-1:0] credit_d [NREQ];
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    sn_d     = sn_q;
    i_d      = i_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    grant_d  = '0;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          sn_d    = '0;
          i_d     = WIDTH'(1);
          ptr_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          for (int k = 0; k < NREQ; k++) credit_d[k] = '0;
        end
      end
      ST_RUN: begin
        if (pick_valid && i_q <= LIMIT_W) begin
          sn_d               = sn_q + WIDTH'(1);
          i_d                = i_q + WIDTH'(1);
          credit_d[pick_idx] = credit_q[pick_idx] + WIDTH'(1);
          grant_d            = pick_onehot;
          ptr_d              = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
          // The increment that lands i on LIMIT+1 also closes the run.
          if (i_q == LIMIT_W) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sn_q    <= '0;
      i_q     <= WIDTH'(1);
      ptr_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NREQ; k++) credit_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      sn_q     <= sn_d;
      i_q      <= i_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      credit_q <= credit_d;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_credit
    assign credit[g*WIDTH +: WIDTH] = credit_q[g];
  end

  assign grant = grant_q;
  assign sn    = sn_q;
  assign i     = i_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tally_arbiter.sv
// Scoreboard bench for tally_arbiter: stimulus pushes expected grants, a monitor pops them,
// and a second monitor checks the tally invariants on every cycle.
module tb_tally_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LIMIT = 70;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_e;
  typedef struct {
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] sn;
    logic [WIDTH-1:0] i;
    logic             dn;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst, start;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      sn, i;
  logic [NREQ*WIDTH-1:0] credit;
  logic                  busy, done;

  tally_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .req    (req),
    .grant  (grant),
    .sn     (sn),
    .i      (i),
    .credit (credit),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_fails  = 0;
  exp_t    exp_q[$];
  logic    mon_en = 1'b0;
  logic    inv_en = 1'b0;
  mstate_e m_state;
  int      m_sn, m_i, m_ptr;
  int      m_cred [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, advances the model for the coming edge, and queues any grant.
  task automatic drive(input logic st, input logic [NREQ-1:0] r, input logic rs);
    exp_t e;
    int   w;
    start = st;
    req   = r;
    rst   = rs;
    if (rs) begin
      m_state = M_IDLE;
      m_sn = 0; m_i = 1; m_ptr = 0;
      for (int k = 0; k < NREQ; k++) m_cred[k] = 0;
    end else if (m_state != M_RUN) begin
      if (st) begin
        m_state = M_RUN;
        m_sn = 0; m_i = 1; m_ptr = 0;
        for (int k = 0; k < NREQ; k++) m_cred[k] = 0;
      end
    end else if (r != '0) begin
      w = -1;
      for (int off = 0; off < NREQ; off++)
        if (w < 0 && r[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
      e.g  = NREQ'(1) << w;
      e.sn = WIDTH'(m_sn + 1);
      e.i  = WIDTH'(m_i + 1);
      e.dn = (m_i == LIMIT);
      exp_q.push_back(e);
      m_sn++; m_i++; m_cred[w]++;
      m_ptr = (w + 1) % NREQ;
      if (e.dn) m_state = M_DONE;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sn"}, 32'(sn), 32'(m_sn));
    check({tag, "_i"}, 32'(i), 32'(m_i));
    check({tag, "_busy"}, 32'(busy), 32'(m_state == M_RUN));
    check({tag, "_done"}, 32'(done), 32'(m_state == M_DONE));
    for (int k = 0; k < NREQ; k++)
      check($sformatf("%s_credit%0d", tag, k), 32'(credit[k*WIDTH +: WIDTH]), 32'(m_cred[k]));
  endtask

  // Grant monitor: every non-zero grant must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && grant !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant", 32'(grant), 32'(e.g));
        check("sb_sn", 32'(sn), 32'(e.sn));
        check("sb_i", 32'(i), 32'(e.i));
        check("sb_done", 32'(done), 32'(e.dn));
      end
    end
  end

  // Invariant monitor.
  always @(negedge clk) begin
    int sum;
    if (inv_en) begin
      sum = 0;
      for (int k = 0; k < NREQ; k++) sum += int'(credit[k*WIDTH +: WIDTH]);
      check("inv_sn_eq_i_minus_1", 32'(sn), 32'(i) - 32'd1);
      check("inv_credit_sum", 32'(sum), 32'(sn));
      check("inv_grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
      check("inv_i_bound", 32'(i <= WIDTH'(LIMIT + 1)), 32'd1);
      if (done) begin
        check("inv_done_sn", 32'(sn), 32'(LIMIT));
        check("inv_done_i", 32'(i), 32'(LIMIT + 1));
      end
    end
  end

  initial begin
    int n;
    logic [NREQ-1:0] r;
    start = 1'b0;
    req   = '0;
    rst   = 1'b1;
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    mon_en = 1'b1;
    check_state("reset");
    check("reset_grant", 32'(grant), 32'd0);

    // Idle with all requests high: nothing moves.
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b1111, 1'b0);
      check_state("idle");
      check("idle_grant", 32'(grant), 32'd0);
    end

    // Full contention: rotation 0,1,2,3,... until done.
    drive(1'b1, 4'b1111, 1'b0);
    inv_en = 1'b1;
    check("start_busy", 32'(busy), 32'd1);
    check("start_grant", 32'(grant), 32'd0);
    n = 0;
    while (!done && n < 200) begin
      drive(1'b0, 4'b1111, 1'b0);
      n++;
    end
    check("full_grant_count", 32'(n), 32'd70);
    check("full_sn", 32'(sn), 32'd70);
    check("full_i", 32'(i), 32'd71);
    check("full_credit0", 32'(credit[0 +: 8]), 32'd18);
    check("full_credit1", 32'(credit[8 +: 8]), 32'd18);
    check("full_credit2", 32'(credit[16 +: 8]), 32'd17);
    check("full_credit3", 32'(credit[24 +: 8]), 32'd17);
    check("full_busy", 32'(busy), 32'd0);

    // Requests ignored in DONE, then restart.
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 4'b1111, 1'b0);
      check_state("done_hold");
      check("done_hold_grant", 32'(grant), 32'd0);
    end
    drive(1'b1, 4'b1111, 1'b0);
    check_state("restart");
    check("restart_i", 32'(i), 32'd1);

    // Single requester owns every grant.
    n = 0;
    while (!done && n < 200) begin
      drive(1'b0, 4'b0100, 1'b0);
      n++;
      if (n == 69) check("single_busy_at_69", 32'(done), 32'd0);
    end
    check("single_grant_count", 32'(n), 32'd70);
    check("single_credit2", 32'(credit[16 +: 8]), 32'd70);
    check("single_credit_others", 32'({credit[31:24], credit[15:0]}), 32'd0);

    // Gappy random traffic.
    drive(1'b1, 4'b0000, 1'b0);
    n = 0;
    while (!done && n < 1000) begin
      r = ($urandom_range(0, 1) == 1) ? NREQ'($urandom_range(1, 15)) : '0;
      drive(1'b0, r, 1'b0);
      check_state("rand");
      if (r == '0) check("rand_idle_grant", 32'(grant), 32'd0);
      n++;
    end
    check("rand_reached_done", 32'(done), 32'd1);

    // Reset mid-run at i=35 together with start.
    drive(1'b1, 4'b1111, 1'b0);
    n = 0;
    while (i != 8'd35 && n < 100) begin
      drive(1'b0, 4'b1111, 1'b0);
      n++;
    end
    check("midrun_i", 32'(i), 32'd35);
    drive(1'b1, 4'b1111, 1'b1);
    check_state("rst_midrun");
    check("rst_midrun_i", 32'(i), 32'd1);
    drive(1'b0, 4'b1111, 1'b0);
    check_state("post_rst_idle");
    check("post_rst_grant", 32'(grant), 32'd0);

    @(negedge clk);
    check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
